// File: rtl/dadda_mult_pipe.sv
// -----------------------------------------------------------------------------
// dadda_mult_pipe
//   Three-stage pipelined WIDTH x WIDTH multiplier built on a Dadda reduction
//   tree. Each transaction is either unsigned or two's-complement. Signed
//   operation uses the modified Baugh-Wooley form: selected partial products
//   are inverted and constant ones are injected, so one tree serves both modes.
//
//   Stage 1 registers the operands and the signed flag.
//   Stage 2 builds the partial products, reduces them to two rows and
//   registers both rows.
//   Stage 3 adds the rows with a ripple-carry adder into out_product.
//   Each stage can load whenever it is empty or its downstream stage is
//   loading, so a full pipeline still accepts and drains in the same cycle.
//
// Parameters
//   WIDTH     : operand width, 4..32; the product is 2*WIDTH bits
//   SIGNED_EN : 1 = in_signed is honoured, 0 = every operation is unsigned
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : operand pair present
//   in_ready    : operands are accepted this cycle
//   in_a, in_b  : multiplicand, multiplier
//   in_signed   : 1 = two's-complement operation
//   out_valid   : out_product holds a result
//   out_ready   : consumer takes the result this cycle
//   out_product : full-width product, held while stalled
// -----------------------------------------------------------------------------
module dadda_mult_pipe #(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product
);

    localparam int PW   = 2 * WIDTH;  // product width / number of columns
    localparam int MAXH = WIDTH + 2;  // column capacity, with room for carries

    // Dadda target heights: index 0 is the final two-row target.
    function automatic int dadda_h(input int s);
        case (s)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            3:       return 6;
            4:       return 9;
            5:       return 13;
            6:       return 19;
            default: return 28;
        endcase
    endfunction

    // Partial-product generation and Dadda reduction. Returns {row1, row0}.
    // Columns are bit buckets with a fill count. For each target height, a
    // column is reduced from the LSB up. Its height includes the carries
    // already pushed in from the column below. A half adder is used when
    // exactly one bit must go, and a full adder otherwise.
    function automatic logic [2*PW-1:0] dadda_tree(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn
    );
        logic [MAXH-1:0] cur   [PW];
        logic [MAXH-1:0] nxt   [PW];
        int              cur_n [PW];
        int              nxt_n [PW];
        logic [PW-1:0]   row0;
        logic [PW-1:0]   row1;
        logic            pp;
        logic            x;
        logic            y;
        logic            z;
        logic            sum;
        logic            cy;
        int              h;
        int              idx;
        int              d;

        // NOTE: blocking assignments are right here: these locals are
        // combinational scratch values read back in program order.
        for (int c = 0; c < PW; c++) begin
            cur[c]   = '0;
            cur_n[c] = 0;
        end

        // A partial product with exactly one sign-bit operand is inverted in
        // signed mode (Baugh-Wooley).
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = a[j] & b[i];
                if ((i == WIDTH - 1) != (j == WIDTH - 1))
                    pp = pp ^ sgn;
                cur[i+j][cur_n[i+j]] = pp;
                cur_n[i+j]           = cur_n[i+j] + 1;
            end
        end
        // Correction constants 2^WIDTH and 2^(2*WIDTH-1). Both are zero in
        // unsigned mode.
        cur[WIDTH][cur_n[WIDTH]] = sgn;
        cur_n[WIDTH]             = cur_n[WIDTH] + 1;
        cur[PW-1][cur_n[PW-1]]   = sgn;
        cur_n[PW-1]              = cur_n[PW-1] + 1;

        // A stage whose target is at or above the current height does nothing.
        for (int s = 7; s >= 0; s--) begin
            d = dadda_h(s);
            for (int c = 0; c < PW; c++) begin
                nxt[c]   = '0;
                nxt_n[c] = 0;
            end
            for (int c = 0; c < PW; c++) begin
                idx = 0;
                h   = cur_n[c] + nxt_n[c];
                for (int k = 0; k < MAXH; k++) begin
                    if (h > d) begin
                        x = cur[c][idx];
                        y = cur[c][idx+1];
                        if (h == d + 1) begin
                            sum = x ^ y;
                            cy  = x & y;
                            idx = idx + 2;
                            h   = h - 1;
                        end else begin
                            z   = cur[c][idx+2];
                            sum = x ^ y ^ z;
                            cy  = (x & y) | (x & z) | (y & z);
                            idx = idx + 3;
                            h   = h - 2;
                        end
                        nxt[c][nxt_n[c]] = sum;
                        nxt_n[c]         = nxt_n[c] + 1;
                        // A carry out of the top column lies beyond the
                        // 2*WIDTH-bit product and is dropped.
                        if (c + 1 < PW) begin
                            nxt[c+1][nxt_n[c+1]] = cy;
                            nxt_n[c+1]           = nxt_n[c+1] + 1;
                        end
                    end
                end
                // Bits not consumed by an adder pass straight through.
                for (int k = 0; k < MAXH; k++) begin
                    if (k >= idx && k < cur_n[c]) begin
                        nxt[c][nxt_n[c]] = cur[c][k];
                        nxt_n[c]         = nxt_n[c] + 1;
                    end
                end
            end
            cur   = nxt;
            cur_n = nxt_n;
        end

        // Unfilled slots are zero, so short columns pack correctly.
        for (int c = 0; c < PW; c++) begin
            row0[c] = cur[c][0];
            row1[c] = cur[c][1];
        end
        return {row1, row0};
    endfunction

    // Final carry-propagate adder: plain ripple carry.
    function automatic logic [PW-1:0] ripple_add(
        input logic [PW-1:0] x,
        input logic [PW-1:0] y
    );
        logic [PW-1:0] s;
        logic          c;
        c = 1'b0;
        for (int i = 0; i < PW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return s;
    endfunction

    // Pipeline state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_signed;
    logic             s2_valid;
    logic [PW-1:0]    s2_row0;
    logic [PW-1:0]    s2_row1;
    logic             s3_valid;

    logic             r1;
    logic             r2;
    logic             r3;
    logic [2*PW-1:0]  tree_rows;
    logic [PW-1:0]    cpa_sum;

    // Ready chain: a stage can load when it is empty or the stage after it
    // is loading.
    assign r3        = ~s3_valid | out_ready;
    assign r2        = ~s2_valid | r3;
    assign r1        = ~s1_valid | r2;
    assign in_ready  = r1;
    assign out_valid = s3_valid;

    assign tree_rows = dadda_tree(s1_a, s1_b, s1_signed);
    assign cpa_sum   = ripple_add(s2_row0, s2_row1);

    // NOTE: the data registers are reset along with the valid bits, because
    // out_product must read zero after reset and the rest costs nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_signed <= 1'b0;
        end else if (r1) begin
            // NOTE: non-blocking assignments make every stage sample its
            // upstream's pre-edge value, so the stages shift in lockstep.
            s1_valid  <= in_valid;
            s1_a      <= in_a;
            s1_b      <= in_b;
            // With SIGNED_EN = 0 this is constant zero and the Baugh-Wooley
            // inversions and constants fold away.
            s1_signed <= in_signed & (SIGNED_EN != 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_row0  <= '0;
            s2_row1  <= '0;
        end else if (r2) begin
            s2_valid <= s1_valid;
            s2_row0  <= tree_rows[PW-1:0];
            s2_row1  <= tree_rows[2*PW-1:PW];
        end
    end

    // out_product updates only when a valid result enters. A bubble leaves the
    // last product visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid    <= 1'b0;
            out_product <= '0;
        end else if (r3) begin
            s3_valid <= s2_valid;
            if (s2_valid)
                out_product <= cpa_sum;
        end
    end

endmodule

// File: doc/dadda_mult_pipe.md
Name: dadda_mult_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 8x8 Dadda CSA multiplier.
- Multiplies two WIDTH-bit operands, either unsigned or two's-complement, selected per transaction.
- The Dadda tree is split across registered stages, and a valid/ready handshake applies on both sides.
- Sits between an operand-producing datapath and a result consumer that may stall.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..32; product is 2*WIDTH bits.
SIGNED_EN, 1, 1 = honour in_signed; 0 = in_signed ignored and all operations are unsigned (Baugh-Wooley correction logic removed).

Ports:
clk  input  1  clock; all registers on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair present
in_ready  output  1  block accepts operands this cycle
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_signed  input  1  1 = two's-complement operation, 0 = unsigned
out_valid  output  1  out_product holds a result
out_ready  input  1  consumer accepts the result
out_product  output  2*WIDTH  full-width product

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits cleared; out_valid=0; out_product=0; in_ready=1 once the pipeline is empty.
- Reset asserted mid-operation discards all in-flight results. No output appears for them after release.
- Three register stages; each stage holds a valid bit plus data.
  - S1: registers in_a, in_b, in_signed.
  - S2: generates WIDTH x WIDTH partial products, with Baugh-Wooley inversion and constant-one injection when signed. Reduces them by Dadda height sequence 2,3,4,6,9,13,19,28 down to two rows, using half and full adders. Registers the two 2*WIDTH-bit rows.
  - S3: adds the two rows with a ripple carry-propagate adder and registers the result into out_product.
- Latency: an operand accepted on cycle N (in_valid & in_ready) gives out_valid=1 on cycle N+3 when not stalled. Throughput is 1 result per cycle.
- Ready chain (combinational):
  - r3 = ~v3 | out_ready
  - r2 = ~v2 | r3
  - r1 = ~v1 | r2
  - in_ready = r1
- Stage i loads from stage i-1 (or from the input) when ri=1. Its valid bit becomes the upstream valid, or in_valid & in_ready for S1.
- When ri=0, stage i's data and valid hold unchanged.
- out_valid = v3. out_product changes only when r3=1 and a new valid result enters. It is stable while out_valid & ~out_ready.
- Bubbles: when a stage loads with an invalid upstream, its valid clears. Data contents of invalid stages are don't-care, but out_product holds its last value.
- Arithmetic:
  - Unsigned: out_product = in_a * in_b exactly, 2*WIDTH bits, no overflow possible.
  - Signed: exact two's-complement product. The most-negative x most-negative case is exact because 2*WIDTH bits suffice.
- in_signed travels with its operands. Mixed signed and unsigned back-to-back transactions are independent.
- Simultaneous input accept and output drain in a full pipeline: both occur, occupancy stays at 3, and no result is lost or duplicated.
- Results emerge in acceptance order. At most 3 transactions are in flight.
- in_valid without in_ready: operands are not captured. The producer must hold them (standard handshake). The block does not check this.

Test Plan (WIDTH=8, SIGNED_EN=1 unless stated):
1. Reset then unsigned 255*255, out_ready=1 → out_valid high exactly 3 cycles after accept; out_product=0xFE01; out_valid=0 next cycle if no new input.
2. Signed back-to-back, one per cycle: (-128)*(-128), (-1)*1, 127*(-128), 0*(-5) → 0x4000, 0xFFFF, 0xC080, 0x0000 on consecutive cycles, in order.
3. Backpressure: send 4 unsigned ops (3*5, 7*9, 11*13, 2*2) with out_ready=0 → in_ready drops after 3 accepts; out_product holds 0x000F stable. Raise out_ready → 0x000F, 0x003F, 0x008F, 0x0004 on consecutive cycles with no loss.
4. Assert rst_n low for 1 cycle while 3 ops are in flight → out_valid=0 and out_product=0 immediately (asynchronous). No stale result appears after release. in_ready=1.
5. SIGNED_EN=0, in_signed=1, 0xFF*0xFF → 0xFE01 (unsigned result). Then WIDTH=16, signed 0x8000*0x8000 → 0x40000000.
6. Randomised 10k transactions with random in_valid/out_ready, against a behavioural golden model (signed and unsigned) → every result matches in order; out_product never changes while out_valid & ~out_ready.
